seq_shift_add_multplr: RTL and testbench
========================================

Name: seq_shift_add_multplr

Overview:
Parametrised sequential shift-and-add multiplier. It is the next-generation replacement for the fixed 4-bit combinational array multiplier in the multiplier/display designs. It trades area for latency: one partial product is accumulated per clock. A start/busy/done handshake lets a display or control wrapper launch an operation and capture a registered product. It supports any operand width and an optional two's-complement signed mode.

Parameters:
WIDTH, 8, operand width in bits; must be at least 2. The product is 2*WIDTH bits.
SIGNED, 0, 0 = unsigned operands and product; 1 = two's-complement operands and product.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
clr  input  1  synchronous active-high reset.
start  input  1  request a multiply; sampled on clk.
a  input  WIDTH  multiplicand; sampled only on the cycle start is accepted.
b  input  WIDTH  multiplier; sampled only on the cycle start is accepted.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse when product has just been updated.
product  output  2*WIDTH  registered result; holds its value between operations.

Behaviour:
- Reset (clr=1 at an edge):
  - state goes to IDLE.
  - busy=0, done=0, product=0.
  - Internal accumulator, counter and operand registers are cleared.
  - clr overrides start and any in-flight operation; a partial result is discarded and never reaches product.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE, start=1 at edge T0:
  - Latch a and b.
  - SIGNED=1: store the magnitudes |a| and |b| and record neg = a[MSB] XOR b[MSB]. The magnitude of the most negative value is 2^(WIDTH-1), so the magnitude registers are WIDTH bits, unsigned.
  - Clear the accumulator, load the counter with WIDTH, enter RUN.
- RUN, each edge:
  - If the multiplier register LSB is 1, add the multiplicand to the upper accumulator half. Keep the carry: the adder is WIDTH+1 bits wide.
  - Shift {carry, accumulator, multiplier} right by 1 and decrement the counter.
- Last RUN cycle (the counter reaches 0 at this edge):
  - Write product = final accumulator (SIGNED=1 and neg=1: the two's-complement negation, modulo 2^(2*WIDTH)).
  - Assert done for exactly the following cycle and return to IDLE.
- Latency:
  - start accepted at T0; busy=1 during cycles T0+1 .. T0+WIDTH.
  - product valid and done=1 in cycle T0+WIDTH+1.
  - Total of WIDTH+1 clocks from start to done.
- start while busy=1 is ignored; no queuing and no restart. a and b may change freely while busy.
- start asserted in the done cycle (state IDLE) is accepted: back-to-back operations run with no dead cycle beyond done.
- start held high continuously restarts on every done cycle.
- product is not modified during RUN. The previous result remains visible until the new done.
- Zero operands:
  - No early termination; latency is always WIDTH+1.
  - SIGNED=1 with a zero magnitude gives product=0, never negative zero.
- Arithmetic is exact; overflow cannot occur.
  - Unsigned range: up to (2^WIDTH-1)^2.
  - Signed range: down to -2^(WIDTH-1)*(2^(WIDTH-1)-1), up to (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2).

Test Plan:
1. WIDTH=8, SIGNED=0, clr then a=8'h0F, b=8'h0F, start pulse -> busy high 8 cycles, done 1 cycle at T0+9, product=16'h00E1; product=0 before done.
2. WIDTH=8, SIGNED=0: a=8'hFF, b=8'hFF -> product=16'hFE01. Then a=8'h00, b=8'hA5 -> product=16'h0000, still 9-cycle latency.
3. WIDTH=8, SIGNED=1:
   - a=8'hFD (-3), b=8'h05 -> product=16'hFFF1.
   - a=8'h80, b=8'h80 -> product=16'h4000.
   - a=8'h80, b=8'h7F -> product=16'hC080.
4. Start 3 cycles into an operation with different a/b -> ignored; the first result completes unchanged, and only one done pulse appears.
5. Hold start=1 with operands changing each done -> consecutive done pulses exactly 9 cycles apart, each product matching the operands sampled at its accept cycle.
6. Assert clr mid-RUN (cycle T0+4) -> the next cycle shows busy=0, done=0, product=0; no done follows. A subsequent start completes normally.
7. Random regression over WIDTH=4 and 16, both SIGNED values: compare product against the reference a*b at every done pulse.

Source files
------------

// File: rtl/seq_shift_add_multplr.sv
// Sequential shift-and-add multiplier.
// One partial product is accumulated per clock; a start/busy/done handshake
// launches an operation and a registered product holds the last result.
// SIGNED=1 multiplies magnitudes and restores the sign on the final write.
module seq_shift_add_multplr #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  // Counter must hold the value WIDTH itself.
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]      mcand_q, mcand_d;
  logic [WIDTH-1:0]      mplier_q, mplier_d;
  logic [WIDTH-1:0]      acc_q, acc_d;
  logic                  neg_q, neg_d;
  logic [2*WIDTH-1:0]    product_q, product_d;
  logic                  done_q, done_d;

  logic [WIDTH:0]        sum;
  logic [WIDTH-1:0]      acc_shift;
  logic [WIDTH-1:0]      mplier_shift;
  logic                  last;

  // Unsigned magnitude of an operand; the most negative value maps to
  // 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    if (SIGNED && v[WIDTH-1]) begin
      return -v;
    end
    return v;
  endfunction

  // Restore the sign of the result; negating zero yields zero, so there is
  // no negative-zero case.
  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] mag,
                                                    input logic              neg);
    if (neg) begin
      return -mag;
    end
    return mag;
  endfunction

  // Partial-product adder and the one-bit right shift of {carry, acc, mplier}.
  always_comb begin
    sum          = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    acc_shift    = sum[WIDTH:1];
    mplier_shift = {sum[0], mplier_q[WIDTH-1:1]};
    last         = (cnt_q == CNT_W'(1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start is only honoured in IDLE, RUN lasts WIDTH cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state and registered datapath values.
  always_comb begin
    busy    = (state_q == RUN);
    done    = done_q;
    product = product_q;
  end

  // Datapath next-state: load on accept, accumulate/shift in RUN, write
  // the product only on the last RUN edge so it is stable during RUN.
  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = magnitude(a);
          mplier_d = magnitude(b);
          neg_d    = SIGNED ? (a[WIDTH-1] ^ b[WIDTH-1]) : 1'b0;
          acc_d    = '0;
          cnt_d    = CNT_W'(WIDTH);
        end
      end
      RUN: begin
        acc_d    = acc_shift;
        mplier_d = mplier_shift;
        cnt_d    = cnt_q - CNT_W'(1);
        if (last) begin
          product_d = apply_sign({acc_shift, mplier_shift}, neg_q);
          done_d    = 1'b1;
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; clr discards any in-flight partial result.
  always_ff @(posedge clk) begin
    if (clr) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multplr.sv
// Bench for seq_shift_add_multplr: six instances covering WIDTH 8/4/16 in
// both signedness modes, driven one at a time with a shared operand bus.
module tb_seq_shift_add_multplr;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [5:0]  st  = '0;
  logic [15:0] a_s = '0;
  logic [15:0] b_s = '0;
  logic [5:0]  bz;
  logic [5:0]  dn;
  logic [15:0] p0, p1;
  logic [7:0]  p2, p3;
  logic [31:0] p4, p5;

  int WV[6] = '{8, 8, 4, 4, 16, 16};
  int SV[6] = '{0, 1, 0, 1, 0, 1};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [31:0] sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_shift_add_multplr #(.WIDTH(8),  .SIGNED(1'b0)) u0 (.clk(clk), .clr(clr), .start(st[0]), .a(a_s[7:0]),  .b(b_s[7:0]),  .busy(bz[0]), .done(dn[0]), .product(p0));
  seq_shift_add_multplr #(.WIDTH(8),  .SIGNED(1'b1)) u1 (.clk(clk), .clr(clr), .start(st[1]), .a(a_s[7:0]),  .b(b_s[7:0]),  .busy(bz[1]), .done(dn[1]), .product(p1));
  seq_shift_add_multplr #(.WIDTH(4),  .SIGNED(1'b0)) u2 (.clk(clk), .clr(clr), .start(st[2]), .a(a_s[3:0]),  .b(b_s[3:0]),  .busy(bz[2]), .done(dn[2]), .product(p2));
  seq_shift_add_multplr #(.WIDTH(4),  .SIGNED(1'b1)) u3 (.clk(clk), .clr(clr), .start(st[3]), .a(a_s[3:0]),  .b(b_s[3:0]),  .busy(bz[3]), .done(dn[3]), .product(p3));
  seq_shift_add_multplr #(.WIDTH(16), .SIGNED(1'b0)) u4 (.clk(clk), .clr(clr), .start(st[4]), .a(a_s),       .b(b_s),       .busy(bz[4]), .done(dn[4]), .product(p4));
  seq_shift_add_multplr #(.WIDTH(16), .SIGNED(1'b1)) u5 (.clk(clk), .clr(clr), .start(st[5]), .a(a_s),       .b(b_s),       .busy(bz[5]), .done(dn[5]), .product(p5));

  function automatic logic [31:0] get_pr(int k);
    case (k)
      0: return {16'h0, p0};
      1: return {16'h0, p1};
      2: return {24'h0, p2};
      3: return {24'h0, p3};
      4: return p4;
      default: return p5;
    endcase
  endfunction

  // Reference product: sign-extend per mode, multiply, wrap to 2*WIDTH bits.
  function automatic logic [31:0] ref_mul(int k, logic [15:0] av, logic [15:0] bv);
    longint m = (longint'(1) << WV[k]) - 1;
    longint x = longint'(av) & m;
    longint y = longint'(bv) & m;
    longint p;
    if (SV[k] != 0 && x[WV[k]-1]) x = x - (longint'(1) << WV[k]);
    if (SV[k] != 0 && y[WV[k]-1]) y = y - (longint'(1) << WV[k]);
    p = (x * y) & ((longint'(1) << (2 * WV[k])) - 1);
    return p[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one start pulse and record the expected product.
  task automatic launch(int k, logic [15:0] av, logic [15:0] bv, logic [31:0] ex);
    a_s = av;
    b_s = bv;
    st[k] = 1'b1;
    sbq.push_back(ex);
    tick();
    st[k] = 1'b0;
  endtask

  // Wait for done, checking busy and a stable product meanwhile, then pop
  // the scoreboard and check latency and result. n0 = edges already elapsed.
  task automatic finish_op(int k, string nm, int n0);
    int n = n0;
    logic [31:0] prev = get_pr(k);
    logic [31:0] ex;
    while (dn[k] !== 1'b1 && n < 64) begin
      n_cmp++;
      if (bz[k] !== 1'b1 || get_pr(k) !== prev) begin
        n_bad++;
        $display("FAIL %s run k=%0d n=%0d busy=%b product=%h required busy=1 product=%h", nm, k, n, bz[k], get_pr(k), prev);
      end
      tick();
      n++;
    end
    ex = (sbq.size() > 0) ? sbq.pop_front() : 32'hxxxx_xxxx;
    n_cmp++;
    if (n !== WV[k]) begin
      n_bad++;
      $display("FAIL %s latency k=%0d got %0d edges after accept, required %0d", nm, k, n, WV[k]);
    end
    n_cmp++;
    if (get_pr(k) !== ex || bz[k] !== 1'b0) begin
      n_bad++;
      $display("FAIL %s product k=%0d got %h busy=%b, required %h busy=0", nm, k, get_pr(k), bz[k], ex);
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    st = '0;
    tick();
    tick();
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (bz[k] !== 1'b0 || dn[k] !== 1'b0 || get_pr(k) !== 32'h0) begin
        n_bad++;
        $display("FAIL reset k=%0d busy=%b done=%b product=%h required 0/0/0", k, bz[k], dn[k], get_pr(k));
      end
    end
    clr = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    n_cmp++;
    if (p0 !== 16'h0) begin
      n_bad++;
      $display("FAIL basic_pre product=%h required 0000", p0);
    end
    launch(0, 16'h0F, 16'h0F, 32'h00E1);
    finish_op(0, "basic", 0);
    tick();
    n_cmp++;
    if (dn[0] !== 1'b0 || p0 !== 16'h00E1) begin
      n_bad++;
      $display("FAIL basic_after done=%b product=%h required done=0 product=00e1", dn[0], p0);
    end
  endtask

  task automatic test_unsigned_edges();
    launch(0, 16'hFF, 16'hFF, 32'hFE01);
    finish_op(0, "max_unsigned", 0);
    tick();
    launch(0, 16'h00, 16'hA5, 32'h0000);
    finish_op(0, "zero_unsigned", 0);
    tick();
  endtask

  task automatic test_signed();
    launch(1, 16'hFD, 16'h05, 32'hFFF1);
    finish_op(1, "signed_neg", 0);
    launch(1, 16'h80, 16'h80, 32'h4000);
    finish_op(1, "signed_minmin", 0);
    launch(1, 16'h80, 16'h7F, 32'hC080);
    finish_op(1, "signed_minmax", 0);
    launch(1, 16'h00, 16'h80, 32'h0000);
    finish_op(1, "signed_zero", 0);
    tick();
  endtask

  task automatic test_ignore_start();
    launch(0, 16'h12, 16'h34, 32'h03A8);
    tick();
    tick();
    a_s = 16'hFF;
    b_s = 16'hFF;
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    finish_op(0, "ignore_start", 3);
    for (int i = 0; i < 12; i++) begin
      tick();
      n_cmp++;
      if (dn[0] !== 1'b0 || bz[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL ignore_extra cycle %0d done=%b busy=%b required 0/0", i, dn[0], bz[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] av[3] = '{16'h03, 16'hFF, 16'h10};
    logic [15:0] bv[3] = '{16'h07, 16'h02, 16'h10};
    logic [31:0] ev[3] = '{32'h0015, 32'h01FE, 32'h0100};
    int last_done = -1;
    a_s = av[0];
    b_s = bv[0];
    sbq.push_back(ev[0]);
    st[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) begin
        st[0] = 1'b0;
      end else begin
        a_s = av[i+1];
        b_s = bv[i+1];
        sbq.push_back(ev[i+1]);
      end
      finish_op(0, "back_to_back", 0);
      if (last_done >= 0) begin
        n_cmp++;
        if (cyc - last_done !== 9) begin
          n_bad++;
          $display("FAIL back_to_back spacing got %0d cycles, required 9", cyc - last_done);
        end
      end
      last_done = cyc;
    end
    tick();
  endtask

  task automatic test_clr_mid_run();
    launch(0, 16'h33, 16'h44, 32'h0D8C);
    tick();
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    void'(sbq.pop_back());
    n_cmp++;
    if (bz[0] !== 1'b0 || dn[0] !== 1'b0 || p0 !== 16'h0) begin
      n_bad++;
      $display("FAIL clr_mid_run busy=%b done=%b product=%h required 0/0/0000", bz[0], dn[0], p0);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      n_cmp++;
      if (dn[0] !== 1'b0 || p0 !== 16'h0) begin
        n_bad++;
        $display("FAIL clr_no_done cycle %0d done=%b product=%h required 0/0000", i, dn[0], p0);
      end
    end
    launch(0, 16'h0A, 16'h0B, 32'h006E);
    finish_op(0, "after_clr", 0);
    tick();
  endtask

  task automatic test_random();
    logic [15:0] av, bv;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 14; i++) begin
        if (i == 0) begin
          av = 16'h1 << (WV[k] - 1);
          bv = av;
        end else if (i == 1) begin
          av = 16'hFFFF;
          bv = 16'h1 << (WV[k] - 1);
        end else begin
          av = 16'($urandom);
          bv = 16'($urandom);
        end
        launch(k, av, bv, ref_mul(k, av, bv));
        finish_op(k, "random", 0);
        repeat ($urandom_range(0, 2)) tick();
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    test_reset();
    test_basic();
    test_unsigned_edges();
    test_signed();
    test_ignore_start();
    test_back_to_back();
    test_clr_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
